// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: configurable payload width, parity mode and stop-bit count.
// Completed words are held behind a valid/ready handshake with parity, framing, break and overrun flags.
module uart_rx_cfg #(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 100000000,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    uart_rxd,
  input  logic                    recv_en,
  input  logic                    recv_ready,
  output logic                    recv_valid,
  output logic [PAYLOAD_BITS-1:0] recv_data,
  output logic                    parity_err,
  output logic                    frame_err,
  output logic                    break_det,
  output logic                    overrun
);

  localparam int CPB   = CLK_HZ / BIT_RATE;
  localparam int CNT_W = $clog2(CPB) + 1;
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF_END  = CNT_W'(CPB / 2 - 1);
  localparam logic [3:0]       LAST_DATA = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
  } state_t;

  function automatic logic parity_bad(input logic [PAYLOAD_BITS-1:0] data, input logic pbit);
    logic x;
    x = (^data) ^ pbit;
    return (PARITY == 1) ? ~x : x;
  endfunction

  state_t                  state;
  logic                    sync_p0, rxd_s;
  logic [CNT_W-1:0]        cnt;
  logic [3:0]              idx;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    armed;
  logic                    par_err_r, fr_err_r, zero_r;
  logic                    done, done_par, done_fr, done_brk;

  logic bit_tick, stop_low, fr_next, zero_next;
  always_comb begin
    bit_tick  = (cnt == BIT_END);
    stop_low  = ~rxd_s;
    fr_next   = fr_err_r | stop_low;
    // Only the first stop bit takes part in break detection.
    zero_next = zero_r & ((idx != 4'd0) | stop_low);
  end

  // Stage: synchroniser and frame FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0   <= 1'b1;
      rxd_s     <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      armed     <= 1'b0;
      par_err_r <= 1'b0;
      fr_err_r  <= 1'b0;
      zero_r    <= 1'b0;
      done      <= 1'b0;
      done_par  <= 1'b0;
      done_fr   <= 1'b0;
      done_brk  <= 1'b0;
    end else begin
      sync_p0 <= uart_rxd;
      rxd_s   <= sync_p0;
      done    <= 1'b0;
      if (!recv_en) begin
        // Disarm so a line already low at re-enable must go high before a start counts.
        state <= S_IDLE;
        cnt   <= '0;
        idx   <= '0;
        armed <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            cnt <= '0;
            idx <= '0;
            if (rxd_s)      armed <= 1'b1;
            else if (armed) state <= S_START;
          end
          S_START: begin
            if (cnt == HALF_END) begin
              cnt <= '0;
              if (rxd_s) begin
                state <= S_IDLE;
              end else begin
                state     <= S_DATA;
                par_err_r <= 1'b0;
                fr_err_r  <= 1'b0;
                zero_r    <= 1'b1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (bit_tick) begin
              cnt    <= '0;
              shreg  <= {rxd_s, shreg[PAYLOAD_BITS-1:1]};
              zero_r <= zero_r & ~rxd_s;
              if (idx == LAST_DATA) begin
                idx   <= '0;
                state <= (PARITY != 0) ? S_PAR : S_STOP;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_PAR: begin
            if (bit_tick) begin
              cnt       <= '0;
              par_err_r <= parity_bad(shreg, rxd_s);
              zero_r    <= zero_r & ~rxd_s;
              state     <= S_STOP;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_STOP: begin
            if (bit_tick) begin
              cnt      <= '0;
              fr_err_r <= fr_next;
              zero_r   <= zero_next;
              if (idx == LAST_STOP) begin
                idx      <= '0;
                done     <= 1'b1;
                done_par <= par_err_r;
                done_fr  <= fr_next;
                done_brk <= zero_next;
                state    <= fr_next ? S_WAIT_HIGH : S_IDLE;
              end else begin
                idx <= idx + 4'd1;
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_WAIT_HIGH: begin
            if (rxd_s) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Stage: output word register and handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      recv_valid <= 1'b0;
      recv_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!recv_valid || recv_ready) begin
          recv_valid <= 1'b1;
          recv_data  <= shreg;
          parity_err <= done_par;
          frame_err  <= done_fr;
          break_det  <= done_brk;
        end else begin
          overrun <= 1'b1;
        end
      end else if (recv_valid && recv_ready) begin
        recv_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 instance and a 7E2 instance at 16 clocks per bit,
// checked through expected-word queues popped on each accepted handshake.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset;
  logic rxd_a, en_a, ready_a, valid_a, perr_a, ferr_a, brk_a, ovr_a;
  logic [7:0] data_a;
  logic rxd_b, en_b, ready_b, valid_b, perr_b, ferr_b, brk_b, ovr_b;
  logic [6:0] data_b;

  always #5 clk = ~clk;

  uart_rx_cfg #(.BIT_RATE(1000000), .CLK_HZ(16000000), .PAYLOAD_BITS(8),
                .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .uart_rxd(rxd_a), .recv_en(en_a), .recv_ready(ready_a),
    .recv_valid(valid_a), .recv_data(data_a), .parity_err(perr_a), .frame_err(ferr_a),
    .break_det(brk_a), .overrun(ovr_a));

  uart_rx_cfg #(.BIT_RATE(1000000), .CLK_HZ(16000000), .PAYLOAD_BITS(7),
                .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .uart_rxd(rxd_b), .recv_en(en_b), .recv_ready(ready_b),
    .recv_valid(valid_b), .recv_data(data_b), .parity_err(perr_b), .frame_err(ferr_b),
    .break_det(brk_b), .overrun(ovr_b));

  typedef struct packed {
    logic [8:0] data;
    logic       par;
    logic       fr;
    logic       brk;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int checks = 0;
  int errors = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_b = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit sel, input logic [8:0] d, input logic p, input logic f,
                      input logic b);
    exp_t e;
    e.data = d; e.par = p; e.fr = f; e.brk = b;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rxd_b = v;
    else     rxd_a = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input int nb, input int pmode,
                      input bit pflip, input int ns);
    logic p;
    p = 1'b0;
    set_line(sel, 1'b0);
    idle(CPB);
    for (int i = 0; i < nb; i++) begin
      set_line(sel, d[i]);
      p = p ^ d[i];
      idle(CPB);
    end
    if (pmode != 0) begin
      if (pmode == 1) p = ~p;
      set_line(sel, p ^ pflip);
      idle(CPB);
    end
    for (int i = 0; i < ns; i++) begin
      set_line(sel, 1'b1);
      idle(CPB);
    end
  endtask

  always @(negedge clk) begin
    if (ovr_a) ovr_cnt_a++;
    if (ovr_b) ovr_cnt_b++;
    if (!reset && valid_a && ready_a) begin
      if (q_a.size() == 0) chk("a_unexpected_word", {24'd0, data_a}, 32'hFFFF_FFFF);
      else begin
        ea = q_a.pop_front();
        chk("a_data", {24'd0, data_a}, {23'd0, ea.data});
        chk("a_parity_err", {31'd0, perr_a}, {31'd0, ea.par});
        chk("a_frame_err", {31'd0, ferr_a}, {31'd0, ea.fr});
        chk("a_break", {31'd0, brk_a}, {31'd0, ea.brk});
      end
    end
    if (!reset && valid_b && ready_b) begin
      if (q_b.size() == 0) chk("b_unexpected_word", {25'd0, data_b}, 32'hFFFF_FFFF);
      else begin
        eb = q_b.pop_front();
        chk("b_data", {25'd0, data_b}, {23'd0, eb.data});
        chk("b_parity_err", {31'd0, perr_b}, {31'd0, eb.par});
        chk("b_frame_err", {31'd0, ferr_b}, {31'd0, eb.fr});
        chk("b_break", {31'd0, brk_b}, {31'd0, eb.brk});
      end
    end
  end

  initial begin
    int n;
    int ovr_base;
    reset = 1'b1;
    rxd_a = 1'b1; en_a = 1'b1; ready_a = 1'b1;
    rxd_b = 1'b1; en_b = 1'b1; ready_b = 1'b1;
    idle(3);
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_data", {24'd0, data_a}, 32'd0);
    chk("rst_flags", {28'd0, perr_a, ferr_a, brk_a, ovr_a}, 32'd0);
    chk("rst_valid_b", {31'd0, valid_b}, 32'd0);
    reset = 1'b0;
    idle(20);

    // 8N1 word with latency measurement
    push(0, 9'h0A5, 0, 0, 0);
    fork
      send(0, 9'h0A5, 8, 0, 0, 1);
      begin
        n = 0;
        while (!valid_a && n < 300) begin
          @(posedge clk); #1;
          n++;
        end
        chk("latency_in_window", {31'd0, (n >= 154 && n <= 156)}, 32'd1);
      end
    join
    idle(8);

    // 7E2: good parity then flipped parity
    push(1, 9'h055, 0, 0, 0);
    send(1, 9'h055, 7, 2, 0, 2);
    push(1, 9'h055, 1, 0, 0);
    send(1, 9'h055, 7, 2, 1, 2);
    idle(8);

    // Break: line low for 12 bit-times, then a clean frame
    push(0, 9'h000, 0, 1, 1);
    set_line(0, 1'b0);
    idle(12 * CPB);
    set_line(0, 1'b1);
    idle(2 * CPB);
    push(0, 9'h03C, 0, 0, 0);
    send(0, 9'h03C, 8, 0, 0, 1);
    idle(8);

    // Overrun: consumer stalled across two back-to-back frames
    ready_a = 1'b0;
    ovr_base = ovr_cnt_a;
    push(0, 9'h011, 0, 0, 0);
    send(0, 9'h011, 8, 0, 0, 1);
    send(0, 9'h022, 8, 0, 0, 1);
    idle(4);
    chk("overrun_pulses", ovr_cnt_a - ovr_base, 32'd1);
    chk("held_valid", {31'd0, valid_a}, 32'd1);
    chk("held_data", {24'd0, data_a}, 32'h11);
    ready_a = 1'b1;
    idle(3);
    chk("valid_after_accept", {31'd0, valid_a}, 32'd0);

    // Glitch shorter than half a bit
    set_line(0, 1'b0);
    idle(4);
    set_line(0, 1'b1);
    idle(3 * CPB);
    chk("glitch_no_valid", {31'd0, valid_a}, 32'd0);
    chk("glitch_no_overrun", ovr_cnt_a - ovr_base, 32'd1);

    // Enable dropped during bit 3
    fork
      send(0, 9'h0F0, 8, 0, 0, 1);
      begin
        repeat (4 * CPB + 8) @(posedge clk);
        #1;
        en_a = 1'b0;
      end
    join
    idle(2);
    en_a = 1'b1;
    idle(CPB);
    chk("abort_no_valid", {31'd0, valid_a}, 32'd0);
    push(0, 9'h00F, 0, 0, 0);
    send(0, 9'h00F, 8, 0, 0, 1);
    idle(8);

    // Reset during bit 5 with a word still pending
    ready_a = 1'b0;
    send(0, 9'h081, 8, 0, 0, 1);
    idle(4);
    chk("pending_before_reset", {31'd0, valid_a}, 32'd1);
    fork
      send(0, 9'h07E, 8, 0, 0, 1);
      begin
        repeat (6 * CPB + 8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("reset_valid", {31'd0, valid_a}, 32'd0);
        chk("reset_data", {24'd0, data_a}, 32'd0);
      end
    join
    idle(2);
    reset = 1'b0;
    ready_a = 1'b1;
    idle(2 * CPB);
    chk("post_reset_no_valid", {31'd0, valid_a}, 32'd0);
    push(0, 9'h099, 0, 0, 0);
    send(0, 9'h099, 8, 0, 0, 1);

    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    chk("queue_a_drained", q_a.size(), 32'd0);
    chk("queue_b_drained", q_b.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receiver. Configurable payload width, parity mode and stop-bit count. Sampling counters are sized from the clock/bit-rate ratio, so any ratio works. Adds a valid/ready output handshake with parity, framing, break and overrun reporting, and sits between the pad-level uart_rxd pin and a byte consumer such as a FIFO or bus bridge.

Parameters:
BIT_RATE, 9600, line bit rate in bits/s.
CLK_HZ, 100000000, clk frequency in Hz. CYCLES_PER_BIT = CLK_HZ/BIT_RATE (integer divide) must be >= 4.
PAYLOAD_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
uart_rxd  in  1  asynchronous serial input, idle high.
recv_en  in  1  receive enable.
recv_ready  in  1  consumer accepts the pending word.
recv_valid  out  1  pending word available; held until accepted.
recv_data  out  PAYLOAD_BITS  received payload, LSB = first bit on the line.
parity_err  out  1  parity mismatch on the pending word.
frame_err  out  1  a stop bit sampled low on the pending word.
break  out  1  pending word is a break: all payload bits, the parity bit (if any) and the first stop bit sampled 0.
overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0, synchroniser flops 1.
- Input path: uart_rxd passes through a 2-flop synchroniser to rxd_s. Only rxd_s is used internally.
- Counter: cycle counter width is clog2(CYCLES_PER_BIT)+1. HALF = CYCLES_PER_BIT/2.
- Sampling: one sample of rxd_s per bit, no majority vote.

FSM:
- IDLE: entered on reset. If recv_en=1 and rxd_s=0, go to START with the counter cleared.
- START: count HALF cycles, then sample.
  - rxd_s=1: false start, return to IDLE, nothing reported.
  - rxd_s=0: clear the counter and go to DATA.
- DATA: every CYCLES_PER_BIT cycles, sample one bit into shift position i (i = 0..PAYLOAD_BITS-1). After the last bit, go to PARITY if PARITY != 0, otherwise to STOP.
- PARITY: after CYCLES_PER_BIT cycles, sample one bit.
  - Odd mode: error if the XOR of payload and parity bit is 0.
  - Even mode: error if that XOR is 1.
- STOP: sample STOP_BITS bits, each CYCLES_PER_BIT apart. Any stop sample of 0 sets the frame error.
- After the last stop sample, the frame is complete. Next state:
  - WAIT_HIGH if frame_err was set (including break). WAIT_HIGH stays until rxd_s=1, then goes to IDLE.
  - IDLE otherwise.

Output update:
- On the clock edge after the final stop sample:
  - If recv_valid=0, or recv_valid=1 and recv_ready=1 in that same cycle: load recv_data, parity_err, frame_err and break, and set recv_valid=1.
  - Else (recv_valid=1, recv_ready=0): drop the new frame, keep the old word and its flags unchanged, and pulse overrun for 1 cycle.
- Handshake: recv_valid clears on the edge where recv_valid and recv_ready are both 1, unless a new word loads on that same edge. Flags are only meaningful while recv_valid=1.

Timing and enable:
- Latency: from the first low of uart_rxd to recv_valid rising is 2 sync cycles + HALF + (PAYLOAD_BITS + P + STOP_BITS)·CYCLES_PER_BIT + 1 cycles (±1 for the synchroniser), where P = 1 if parity is enabled.
- recv_en=0 mid-frame: abort to IDLE on the next edge, discard the partial frame, and do not touch the pending word. A frame starting while recv_en=0 is ignored. Re-enabling while the line is low does not start reception until the line has been seen high, then low.
- Back-to-back frames: a start edge arriving right after the last stop sample must be caught. IDLE re-arms on the very next cycle.
- Asynchronous reset mid-frame: all state returns to reset values immediately, and no recv_valid appears for that frame.

Test Plan:
1. 8N1, CLK_HZ=16000000, BIT_RATE=1000000 (16 cycles/bit), send 0xA5 with recv_ready=1 → recv_valid pulses once, recv_data=0xA5, all error flags 0, timing within ±1 cycle of the latency formula.
2. PAYLOAD_BITS=7, PARITY=2, STOP_BITS=2, send 0x55 with a correct parity bit, then 0x55 with a flipped parity bit → first word parity_err=0, second word parity_err=1, both recv_data=0x55.
3. 8N1, line held low for 12 bit-times, then released → recv_data=0x00, frame_err=1, break=1; no further frame is reported until the line has been high, and a following 0x3C is received cleanly.
4. 8N1, recv_ready=0, send 0x11 then 0x22 back-to-back → recv_valid held with 0x11, overrun pulses one cycle at the end of 0x22; after recv_ready=1, 0x11 is accepted and recv_valid falls.
5. Glitch low for 4 cycles (less than HALF=8) → no reception, FSM back in IDLE, recv_valid stays 0.
6. Mid-frame abort and reset: drop recv_en during bit 3 of 0xF0 → no output, next 0x0F is received correctly. Assert reset during bit 5 of a frame → all outputs 0 immediately, and the next frame is received normally.
